multicycle_ctrl: RTL

//  Moore/Mealy FSM sequencing the multi-cycle datapath: PC, IR, register file, ALU,

---
 rtl/multicycle_ctrl_pkg.sv | 94 +++++++++
 rtl/ctrl_op_decode.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, states, ALU/extender/PC-source
// selects, and the decode and control-word payloads.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned EXT_OP_W = 2;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 3'b101;

  localparam logic [EXT_OP_W-1:0] EXT_SIGN = 2'b00;
  localparam logic [EXT_OP_W-1:0] EXT_ZERO = 2'b01;
  localparam logic [EXT_OP_W-1:0] EXT_LUI  = 2'b10;

  localparam logic [SEL_W-1:0] SRC_B_RT     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_EXT    = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_EXT_SH = 2'b11;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_EXEC_I   = 4'd9,
    ST_WB_I     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_MEM,
    CLS_BR,
    CLS_J,
    CLS_I
  } op_class_e;

  typedef struct packed {
    op_class_e             op_class;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [EXT_OP_W-1:0]   ext_op;
    logic                  is_bne;
    logic                  is_load;
    logic                  illegal;
  } op_dec_t;

  typedef struct packed {
    logic                  pc_write;
    logic                  ir_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  i_or_d;
    logic                  reg_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  alu_src_a;
    logic [SEL_W-1:0]      alu_src_b;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [EXT_OP_W-1:0]   ext_op;
    logic [SEL_W-1:0]      pc_src;
    logic                  illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_op_decode.sv
// Opcode classifier: instruction class plus the ALU/extender selects an I-type needs.
module ctrl_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_dec_t         dec
);

  always_comb begin
    dec.op_class = CLS_NONE;
    dec.alu_op   = ALU_ADD;
    dec.ext_op   = EXT_SIGN;
    dec.is_bne   = 1'b0;
    dec.is_load  = 1'b0;
    dec.illegal  = 1'b0;
    case (op)
      OP_RTYPE: dec.op_class = CLS_R;
      OP_LW: begin
        dec.op_class = CLS_MEM;
        dec.is_load  = 1'b1;
      end
      OP_SW:   dec.op_class = CLS_MEM;
      OP_BEQ:  dec.op_class = CLS_BR;
      OP_BNE: begin
        dec.op_class = CLS_BR;
        dec.is_bne   = 1'b1;
      end
      OP_J:    dec.op_class = CLS_J;
      OP_ADDI: dec.op_class = CLS_I;
      OP_SLTI: begin
        dec.op_class = CLS_I;
        dec.alu_op   = ALU_SLT;
      end
      OP_ORI: begin
        dec.op_class = CLS_I;
        dec.alu_op   = ALU_OR;
        dec.ext_op   = EXT_ZERO;
      end
      OP_LUI: begin
        dec.op_class = CLS_I;
        dec.alu_op   = ALU_PASSB;
        dec.ext_op   = EXT_LUI;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle datapath sequencer: fetch/decode/execute FSM with memory ready stalls.
// Controls are decoded from the state; pc_write also sees mem_ready_i and zero_i.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                ir_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                i_or_d_o,
  output logic                reg_write_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                alu_src_a_o,
  output logic [SEL_W-1:0]    alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [EXT_OP_W-1:0] ext_op_o,
  output logic [SEL_W-1:0]    pc_src_o,
  output logic                illegal_o,
  output logic [STATE_W-1:0]  state_o
);

  state_e  state_q;
  state_e  state_d;
  op_dec_t dec;
  ctrl_t   ctrl;

  // funct only matters to the downstream ALU control
  logic funct_unused;
  assign funct_unused = ^funct_i;

  ctrl_op_decode u_dec (
    .op  (instr_op_i),
    .dec (dec)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        case (dec.op_class)
          CLS_R:   state_d = ST_EXEC_R;
          CLS_MEM: state_d = ST_MEM_ADDR;
          CLS_BR:  state_d = ST_BRANCH;
          CLS_J:   state_d = ST_JUMP;
          CLS_I:   state_d = ST_EXEC_I;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: state_d = dec.is_load ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready_i) state_d = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready_i) state_d = ST_FETCH;
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_MEM_WB, ST_WB_R, ST_WB_I, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      default:     state_d = ST_RST;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRC_B_EXT_SH;
        ctrl.illegal   = dec.illegal;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_EXT;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_EXT;
        ctrl.alu_op    = dec.alu_op;
        ctrl.ext_op    = dec.ext_op;
      end
      // IR is stable, so re-decoding keeps the extender/ALU selects steady into writeback
      ST_WB_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = dec.alu_op;
        ctrl.ext_op    = dec.ext_op;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_write  = zero_i ^ dec.is_bne;
      end
      ST_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

  assign pc_write_o   = ctrl.pc_write;
  assign ir_write_o   = ctrl.ir_write;
  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign i_or_d_o     = ctrl.i_or_d;
  assign reg_write_o  = ctrl.reg_write;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign ext_op_o     = ctrl.ext_op;
  assign pc_src_o     = ctrl.pc_src;
  assign illegal_o    = ctrl.illegal;
  assign state_o      = state_q;

endmodule
